// File: rtl/tvip_axi_burst_beat_generator.sv
// tvip_axi_burst_beat_generator
//
// Expands one AXI burst request into one descriptor per data beat. Each
// descriptor carries the beat address, the active byte lanes, the 0-based
// beat index and a last flag. Illegal bursts still produce every beat, and
// beat_error is held high for the whole burst.
//
// Ports:
//   aclk, areset_n      clock and asynchronous active-low reset
//   req_valid/req_ready request handshake; ready only while idle
//   req_id              burst ID, echoed on beat_id
//   req_address         start address
//   req_length          AxLEN (beats - 1)
//   req_size            AxSIZE (bytes per beat = 1 << size)
//   req_burst           00 FIXED, 01 INCR, 10 WRAP, 11 reserved
//   beat_valid/ready    descriptor handshake
//   beat_address        address of the current beat
//   beat_strobe         active byte lanes of the current beat
//   beat_index          beat number within the burst
//   beat_last           high on the final beat
//   beat_error          burst is illegal
module tvip_axi_burst_beat_generator #(
    parameter int ID_WIDTH      = 8,
    parameter int ADDRESS_WIDTH = 64,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     aclk,
    input  logic                     areset_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ID_WIDTH-1:0]      req_id,
    input  logic [ADDRESS_WIDTH-1:0] req_address,
    input  logic [7:0]               req_length,
    input  logic [2:0]               req_size,
    input  logic [1:0]               req_burst,
    output logic                     beat_valid,
    input  logic                     beat_ready,
    output logic [ID_WIDTH-1:0]      beat_id,
    output logic [ADDRESS_WIDTH-1:0] beat_address,
    output logic [DATA_WIDTH/8-1:0]  beat_strobe,
    output logic [7:0]               beat_index,
    output logic                     beat_last,
    output logic                     beat_error
);

    localparam int STRB   = DATA_WIDTH / 8;
    localparam int LANE_W = (STRB > 1) ? $clog2(STRB) : 1;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    typedef logic [ADDRESS_WIDTH-1:0] addr_t;

    typedef enum logic {
        ST_IDLE,
        ST_BURST
    } state_t;

    state_t state;
    state_t state_next;

    // Latched per-burst parameters
    logic [7:0] length_q;
    logic [2:0] size_q;
    logic [1:0] burst_q;
    addr_t      lower_q;
    addr_t      span_q;

    // Request decode
    addr_t req_bytes;
    addr_t req_beats;
    addr_t req_aligned;
    addr_t req_span;
    addr_t req_lower;
    addr_t req_last_byte;
    logic  req_wrap_len_ok;
    logic  req_error;
    logic  req_fire;

    // Beat advance
    addr_t cur_bytes;
    addr_t wrap_offset;
    addr_t next_address;
    logic  beat_fire;

    // Byte lanes lo..hi of a beat. Only the low address bits matter because
    // STRB is a power of two, so the aligned lane is the low bits masked.
    // Sizes wider than the bus simply saturate at the top lane.
    function automatic logic [STRB-1:0] lane_strobe(
        input logic [LANE_W-1:0] addr_lo,
        input logic [2:0]        size_enc
    );
        logic [15:0]     bytes;
        logic [15:0]     lo;
        logic [15:0]     aligned_lo;
        logic [15:0]     hi;
        logic [STRB-1:0] lanes;
        bytes      = 16'd1 << size_enc;
        lo         = 16'(addr_lo) & 16'(STRB - 1);
        aligned_lo = lo & ~(bytes - 16'd1);
        hi         = aligned_lo + bytes - 16'd1;
        for (int i = 0; i < STRB; i++) begin
            lanes[i] = (16'(i) >= lo) && (16'(i) <= hi);
        end
        return lanes;
    endfunction

    assign req_ready  = (state == ST_IDLE);
    assign beat_valid = (state == ST_BURST);
    assign req_fire   = req_valid && req_ready;
    assign beat_fire  = beat_valid && beat_ready;

    // Decode the incoming request: wrap window and error conditions
    always_comb begin
        req_bytes       = addr_t'(1) << req_size;
        req_beats       = addr_t'(req_length) + addr_t'(1);
        req_aligned     = req_address & ~(req_bytes - addr_t'(1));
        req_span        = req_beats << req_size;
        req_lower       = req_address & ~(req_span - addr_t'(1));
        req_last_byte   = req_aligned + req_span - addr_t'(1);
        req_wrap_len_ok = (req_length == 8'd1) || (req_length == 8'd3) ||
                          (req_length == 8'd7) || (req_length == 8'd15);
        req_error = 1'b0;
        if (req_burst == BURST_RSVD) begin
            req_error = 1'b1;
        end
        if (req_bytes > addr_t'(STRB)) begin
            req_error = 1'b1;
        end
        if ((req_burst == BURST_WRAP) &&
            (!req_wrap_len_ok || ((req_address & (req_bytes - addr_t'(1))) != '0))) begin
            req_error = 1'b1;
        end
        // Comparing 4 KB page numbers of the first and last byte
        if ((req_burst == BURST_INCR) &&
            ((req_address >> 12) != (req_last_byte >> 12))) begin
            req_error = 1'b1;
        end
    end

    // Address of the following beat. WRAP folds back to the window base once
    // the offset reaches the window size; INCR realigns after beat 0.
    always_comb begin
        cur_bytes    = addr_t'(1) << size_q;
        wrap_offset  = beat_address - lower_q + cur_bytes;
        next_address = beat_address;
        case (burst_q)
            BURST_FIXED: next_address = beat_address;
            BURST_WRAP:  next_address = (wrap_offset >= span_q) ? lower_q
                                                                  : beat_address + cur_bytes;
            default:     next_address = (beat_address & ~(cur_bytes - addr_t'(1))) + cur_bytes;
        endcase
    end

    // State register
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: accept in IDLE, return after the last beat handshake
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (req_valid) state_next = ST_BURST;
            ST_BURST: if (beat_fire && beat_last) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Burst parameters and registered beat outputs. Reserved bursts are
    // walked as INCR; the error flag is what marks them.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            length_q     <= '0;
            size_q       <= '0;
            burst_q      <= '0;
            lower_q      <= '0;
            span_q       <= '0;
            beat_id      <= '0;
            beat_address <= '0;
            beat_strobe  <= '0;
            beat_index   <= '0;
            beat_last    <= 1'b0;
            beat_error   <= 1'b0;
        end else if (req_fire) begin
            length_q     <= req_length;
            size_q       <= req_size;
            burst_q      <= (req_burst == BURST_RSVD) ? BURST_INCR : req_burst;
            lower_q      <= req_lower;
            span_q       <= req_span;
            beat_id      <= req_id;
            beat_address <= req_address;
            beat_strobe  <= lane_strobe(req_address[LANE_W-1:0], req_size);
            beat_index   <= 8'd0;
            beat_last    <= (req_length == 8'd0);
            beat_error   <= req_error;
        end else if (beat_fire && !beat_last) begin
            beat_address <= next_address;
            beat_strobe  <= lane_strobe(next_address[LANE_W-1:0], size_q);
            beat_index   <= beat_index + 8'd1;
            beat_last    <= ((beat_index + 8'd1) == length_q);
        end
    end

endmodule

// File: tb/tb_tvip_axi_burst_beat_generator.sv
// Testbench for tvip_axi_burst_beat_generator (32-bit bus, 64-bit address).
module tb_tvip_axi_burst_beat_generator;

    localparam int ID_W = 8;
    localparam int AW   = 64;
    localparam int DW   = 32;
    localparam int STRB = DW / 8;

    logic            aclk = 1'b0;
    logic            areset_n;
    logic            req_valid;
    logic            req_ready;
    logic [ID_W-1:0] req_id;
    logic [AW-1:0]   req_address;
    logic [7:0]      req_length;
    logic [2:0]      req_size;
    logic [1:0]      req_burst;
    logic            beat_valid;
    logic            beat_ready;
    logic [ID_W-1:0] beat_id;
    logic [AW-1:0]   beat_address;
    logic [STRB-1:0] beat_strobe;
    logic [7:0]      beat_index;
    logic            beat_last;
    logic            beat_error;

    always #5 aclk = ~aclk;

    tvip_axi_burst_beat_generator #(
        .ID_WIDTH      (ID_W),
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW)
    ) dut (
        .aclk         (aclk),
        .areset_n     (areset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_id       (req_id),
        .req_address  (req_address),
        .req_length   (req_length),
        .req_size     (req_size),
        .req_burst    (req_burst),
        .beat_valid   (beat_valid),
        .beat_ready   (beat_ready),
        .beat_id      (beat_id),
        .beat_address (beat_address),
        .beat_strobe  (beat_strobe),
        .beat_index   (beat_index),
        .beat_last    (beat_last),
        .beat_error   (beat_error)
    );

    typedef struct packed {
        logic [7:0]  id;
        logic [63:0] addr;
        logic [3:0]  strb;
        logic [7:0]  index;
        logic        last;
        logic        err;
    } beat_t;

    typedef struct {
        logic [7:0]       id;
        logic [63:0]      addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic             err;
        logic [3:0][63:0] exp_addr;
        logic [3:0][3:0]  exp_strb;
    } vec_t;

    beat_t sb[$];
    vec_t  vecs[10];
    int    n_vec  = 0;
    int    n_fail = 0;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: actual 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_beat(input logic [7:0] id, input logic [63:0] addr, input logic [3:0] strb,
                             input int idx, input logic last, input logic err);
        beat_t b;
        b.id    = id;
        b.addr  = addr;
        b.strb  = strb;
        b.index = 8'(idx);
        b.last  = last;
        b.err   = err;
        sb.push_back(b);
    endtask

    // Closed-form reference: address of beat n and its lanes
    task automatic push_model(input logic [7:0] id, input logic [63:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst, input logic err);
        logic [63:0] bytes;
        logic [63:0] aligned;
        logic [63:0] wb;
        logic [63:0] lower;
        logic [63:0] a;
        logic [3:0]  s;
        int          lo;
        int          hi;
        bytes   = 64'd1 << size;
        aligned = addr & ~(bytes - 64'd1);
        wb      = bytes * (64'(len) + 64'd1);
        lower   = addr & ~(wb - 64'd1);
        for (int n = 0; n <= int'(len); n++) begin
            if (burst == 2'b00) begin
                a = addr;
            end else if (burst == 2'b10) begin
                a = lower + ((addr - lower + 64'(n) * bytes) % wb);
            end else begin
                a = (n == 0) ? addr : aligned + 64'(n) * bytes;
            end
            lo = int'(a % 64'd4);
            hi = int'((a & ~(bytes - 64'd1)) % 64'd4) + int'(bytes) - 1;
            for (int i = 0; i < 4; i++) s[i] = (i >= lo) && (i <= hi);
            push_beat(id, a, s, n, n == int'(len), err);
        end
    endtask

    task automatic set_vec(input int k, input logic [7:0] id, input logic [63:0] addr,
                           input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                           input logic err, input logic [63:0] a0, input logic [63:0] a1,
                           input logic [63:0] a2, input logic [63:0] a3, input logic [3:0] s0,
                           input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] s3);
        vecs[k].id    = id;
        vecs[k].addr  = addr;
        vecs[k].len   = len;
        vecs[k].size  = size;
        vecs[k].burst = burst;
        vecs[k].err   = err;
        vecs[k].exp_addr[0] = a0;
        vecs[k].exp_addr[1] = a1;
        vecs[k].exp_addr[2] = a2;
        vecs[k].exp_addr[3] = a3;
        vecs[k].exp_strb[0] = s0;
        vecs[k].exp_strb[1] = s1;
        vecs[k].exp_strb[2] = s2;
        vecs[k].exp_strb[3] = s3;
    endtask

    // Drive a request and return at posedge+1 after its handshake
    task automatic apply_stimulus(input logic [7:0] id, input logic [63:0] addr, input logic [7:0] len,
                                  input logic [2:0] size, input logic [1:0] burst);
        logic got;
        got         = 1'b0;
        req_id      = id;
        req_address = addr;
        req_length  = len;
        req_size    = size;
        req_burst   = burst;
        req_valid   = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge aclk);
            if (req_ready) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge aclk);
        #1;
        req_valid = 1'b0;
        if (!got) begin
            n_vec++;
            n_fail++;
            $display("[TB] FAIL req_handshake_timeout: actual req_ready 0, expected 1");
        end
    endtask

    // Let the scoreboard drain, optionally with random backpressure
    task automatic wait_drain(input bit rnd, input string name);
        for (int c = 0; c < 2000; c++) begin
            @(posedge aclk);
            #1;
            beat_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge aclk);
            if (sb.size() == 0) break;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("[TB] FAIL %s_timeout: actual %0d beats outstanding, expected 0", name, sb.size());
            sb.delete();
        end
        @(posedge aclk);
        #1;
        beat_ready = 1'b1;
        check_output({name, "_req_ready_after"}, 64'(req_ready), 64'd1);
    endtask

    // Scoreboard monitor: compare each handshaken beat against the queue head
    always @(negedge aclk) begin
        if (areset_n && beat_valid && beat_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("[TB] FAIL unexpected_beat: actual beat at 0x%0h index %0d, expected none",
                         beat_address, beat_index);
            end else begin
                beat_t e;
                e = sb.pop_front();
                check_output("beat_address", beat_address, e.addr);
                check_output("beat_strobe", 64'(beat_strobe), 64'(e.strb));
                check_output("beat_id_index_last_error",
                             64'({beat_id, beat_index, beat_last, beat_error}),
                             64'({e.id, e.index, e.last, e.err}));
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: actual simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        areset_n    = 1'b0;
        req_valid   = 1'b0;
        req_id      = '0;
        req_address = '0;
        req_length  = '0;
        req_size    = '0;
        req_burst   = '0;
        beat_ready  = 1'b1;

        //       k  id     addr      len  sz burst err  addresses                                 strobes
        set_vec(0, 8'h5A, 64'h1002, 3, 2, 2'b01, 0, 64'h1002, 64'h1004, 64'h1008, 64'h100C, 4'hC, 4'hF, 4'hF, 4'hF);
        set_vec(1, 8'h11, 64'h38,   3, 2, 2'b10, 0, 64'h38,   64'h3C,   64'h30,   64'h34,   4'hF, 4'hF, 4'hF, 4'hF);
        set_vec(2, 8'h22, 64'h101,  2, 0, 2'b00, 0, 64'h101,  64'h101,  64'h101,  64'h0,    4'h2, 4'h2, 4'h2, 4'h0);
        set_vec(3, 8'h33, 64'hFF8,  3, 2, 2'b01, 1, 64'hFF8,  64'hFFC,  64'h1000, 64'h1004, 4'hF, 4'hF, 4'hF, 4'hF);
        set_vec(4, 8'h44, 64'h0,    1, 3, 2'b01, 1, 64'h0,    64'h8,    64'h0,    64'h0,    4'hF, 4'hF, 4'h0, 4'h0);
        set_vec(5, 8'h55, 64'h30,   2, 2, 2'b10, 1, 64'h30,   64'h34,   64'h38,   64'h0,    4'hF, 4'hF, 4'hF, 4'h0);
        set_vec(6, 8'h66, 64'h20,   1, 2, 2'b11, 1, 64'h20,   64'h24,   64'h0,    64'h0,    4'hF, 4'hF, 4'h0, 4'h0);
        set_vec(7, 8'h77, 64'h3,    2, 1, 2'b01, 0, 64'h3,    64'h4,    64'h6,    64'h0,    4'h8, 4'h3, 4'hC, 4'h0);
        set_vec(8, 8'h88, 64'h10,   0, 2, 2'b01, 0, 64'h10,   64'h0,    64'h0,    64'h0,    4'hF, 4'h0, 4'h0, 4'h0);
        set_vec(9, 8'h99, 64'h5,    1, 0, 2'b10, 0, 64'h5,    64'h4,    64'h0,    64'h0,    4'h2, 4'h1, 4'h0, 4'h0);

        // Reset values
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        check_output("reset_req_ready", 64'(req_ready), 64'd1);
        check_output("reset_beat_valid", 64'(beat_valid), 64'd0);
        check_output("reset_last_error", 64'({beat_last, beat_error}), 64'd0);
        check_output("reset_beat_id", 64'(beat_id), 64'd0);
        check_output("reset_beat_address", beat_address, 64'd0);
        check_output("reset_strobe_index", 64'({beat_strobe, beat_index}), 64'd0);
        @(posedge aclk);
        #1;
        areset_n = 1'b1;

        // Table-driven bursts; odd entries run with random backpressure
        for (int k = 0; k < 10; k++) begin
            for (int n = 0; n <= int'(vecs[k].len); n++) begin
                push_beat(vecs[k].id, vecs[k].exp_addr[n], vecs[k].exp_strb[n], n,
                          n == int'(vecs[k].len), vecs[k].err);
            end
            apply_stimulus(vecs[k].id, vecs[k].addr, vecs[k].len, vecs[k].size, vecs[k].burst);
            wait_drain(k[0], "table");
        end

        // Backpressure on beat 1 for three cycles
        beat_ready = 1'b0;
        for (int n = 0; n < 4; n++) begin
            push_beat(8'h5B, vecs[0].exp_addr[n], vecs[0].exp_strb[n], n, n == 3, 1'b0);
        end
        apply_stimulus(8'h5B, 64'h1002, 8'd3, 3'd2, 2'b01);
        @(negedge aclk);
        check_output("latency_beat_valid", 64'(beat_valid), 64'd1);
        check_output("latency_beat_address", beat_address, 64'h1002);
        @(posedge aclk);
        #1;
        beat_ready = 1'b1;
        @(posedge aclk);
        #1;
        beat_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge aclk);
            check_output("bp_hold_address", beat_address, 64'h1004);
            check_output("bp_hold_ctrl", 64'({beat_valid, beat_strobe, beat_index, beat_last}),
                         64'({1'b1, 4'hF, 8'd1, 1'b0}));
            check_output("bp_req_ready", 64'(req_ready), 64'd0);
            @(posedge aclk);
            #1;
        end
        beat_ready = 1'b1;
        repeat (2) @(negedge aclk);
        @(negedge aclk);
        check_output("bp_last_req_ready", 64'({beat_last, req_ready}), 64'({1'b1, 1'b0}));
        @(negedge aclk);
        check_output("bp_req_ready_rise", 64'({req_ready, beat_valid}), 64'({1'b1, 1'b0}));
        @(posedge aclk);
        #1;

        // 16-beat WRAP crossing its window, then a 256-beat INCR
        push_model(8'hC3, 64'h1234, 8'd15, 3'd2, 2'b10, 1'b0);
        apply_stimulus(8'hC3, 64'h1234, 8'd15, 3'd2, 2'b10);
        wait_drain(1'b0, "wrap16");
        push_model(8'hA5, 64'h0, 8'd255, 3'd2, 2'b01, 1'b0);
        apply_stimulus(8'hA5, 64'h0, 8'd255, 3'd2, 2'b01);
        wait_drain(1'b1, "len256");

        // Reset during beat 2 of an 8-beat INCR
        begin
            logic seen;
            seen = 1'b0;
            push_model(8'h3C, 64'h200, 8'd7, 3'd2, 2'b01, 1'b0);
            apply_stimulus(8'h3C, 64'h200, 8'd7, 3'd2, 2'b01);
            for (int c = 0; c < 50; c++) begin
                @(negedge aclk);
                if (beat_valid && beat_index == 8'd2) begin
                    seen = 1'b1;
                    break;
                end
            end
            check_output("rst_reached_beat2", 64'(seen), 64'd1);
            #2;
            areset_n = 1'b0;
            #1;
            check_output("rst_beat_valid_async", 64'(beat_valid), 64'd0);
            check_output("rst_req_ready", 64'({req_ready, beat_index}), 64'({1'b1, 8'd0}));
            sb.delete();
            repeat (2) @(posedge aclk);
            #1;
            areset_n = 1'b1;
            @(negedge aclk);
            check_output("rst_release_state", 64'({req_ready, beat_valid}), 64'({1'b1, 1'b0}));
            @(posedge aclk);
            #1;
            push_model(8'h4D, 64'h480, 8'd1, 3'd2, 2'b01, 1'b0);
            apply_stimulus(8'h4D, 64'h480, 8'd1, 3'd2, 2'b01);
            wait_drain(1'b0, "after_reset");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
